riscv_run_controller: RTL

Parametrised run/reset sequencer for the single-cycle RISC-V core; replaces fixed-delay reset pulsing and fixed-duration run windows with a synthesizable controller.
- Holds the core in reset for a programmable number of cycles, then runs it while counting cycles.
- Ends the run on self-loop halt detection (PC unchanged) or on a cycle-limit timeout; reports status and halt PC.
- Sits between the system clock/reset and the core's reset input; bench and on-board debug logic observe its outputs.

---
 rtl/riscv_run_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/riscv_run_controller.sv
// rtl/riscv_run_controller.sv - run/reset sequencer for the single-cycle RISC-V core (optional tohost exit via RUN_CTRL_TOHOST_EN)
module riscv_run_controller #(
    parameter int XLEN            = 32,
    parameter int CNT_W           = 32,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int MAX_CYCLES      = 52,
    parameter int STALL_LIMIT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
`ifdef RUN_CTRL_TOHOST_EN
    input  logic             tohost_we,
    input  logic [XLEN-1:0]  tohost_data,
    output logic             pass,
    output logic [XLEN-2:0]  exit_code,
`endif
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timed_out,
    output logic [XLEN-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W  = $clog2(RST_HOLD_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic               TO_EN      = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0]   TO_LAST    = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [XLEN-1:0]    last_pc;
    logic               last_pc_valid;

    logic match;
    logic stall_hit;
    logic to_hit;
    logic tohost_hit;

    // Halt/timeout qualifiers only feed registers, never outputs directly
    assign match     = last_pc_valid && (pc == last_pc);
    assign stall_hit = match && (stall_cnt == STALL_LAST);
    assign to_hit    = TO_EN && (cycle_count == TO_LAST);
`ifdef RUN_CTRL_TOHOST_EN
    assign tohost_hit = tohost_we && (tohost_data != '0);
`else
    assign tohost_hit = 1'b0;
`endif

    // Status flags decoded straight from the state register
    assign running = (state == RUN);
    assign done    = (state == HALTED) || (state == TIMEOUT);

    // Sequencer: hold core in reset, run and count, then latch the end condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HOLD;
            core_rst      <= 1'b1;
            halted        <= 1'b0;
            timed_out     <= 1'b0;
            halt_pc       <= '0;
            cycle_count   <= '0;
            hold_cnt      <= '0;
            stall_cnt     <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
`ifdef RUN_CTRL_TOHOST_EN
            pass          <= 1'b0;
            exit_code     <= '0;
`endif
        end else if (start) begin
            state         <= HOLD;
            core_rst      <= 1'b1;
            halted        <= 1'b0;
            timed_out     <= 1'b0;
            halt_pc       <= '0;
            cycle_count   <= '0;
            hold_cnt      <= '0;
            stall_cnt     <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
`ifdef RUN_CTRL_TOHOST_EN
            pass          <= 1'b0;
            exit_code     <= '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    core_rst <= 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    last_pc       <= pc;
                    last_pc_valid <= 1'b1;
                    stall_cnt     <= match ? stall_cnt + 1'b1 : '0;
                    // tohost exit outranks stall halt, which outranks timeout
                    if (tohost_hit) begin
                        state   <= HALTED;
                        halted  <= 1'b1;
                        halt_pc <= pc;
`ifdef RUN_CTRL_TOHOST_EN
                        exit_code <= tohost_data[XLEN-1:1];
                        pass      <= (tohost_data == XLEN'(1));
`endif
                    end else if (stall_hit) begin
                        state   <= HALTED;
                        halted  <= 1'b1;
                        halt_pc <= pc;
                    end else if (to_hit) begin
                        state     <= TIMEOUT;
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                    // HALTED/TIMEOUT: everything frozen until start or rst
                    core_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule
